// File: rtl/button_debouncer_if.sv
// Button debouncer bundle: the raw pin going in and the conditioned level, strobes and press count coming out.
// The bench side uses the master modport and the debouncer uses the slave modport.
interface button_debouncer_if #(
  parameter int COUNT_W = 8
);
  logic               btn_n_raw;
  logic               btn_level;
  logic               press_pulse;
  logic               release_pulse;
  logic [COUNT_W-1:0] press_count;
  logic               long_press;

  modport master (
    output btn_n_raw,
    input  btn_level, press_pulse, release_pulse, press_count, long_press
  );

  modport slave (
    input  btn_n_raw,
    output btn_level, press_pulse, release_pulse, press_count, long_press
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces an active-low push button into a clean level, press/release strobes and a saturating press count.
// Optional long-press strobe is built only when BTN_LONG_PRESS_EN is defined.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int COUNT_W           = 8,
  parameter int LONG_PRESS_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst,
  button_debouncer_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t             state, state_next, prev_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               sync1, sync2, btn_s;
  logic               level_d, press_d, release_d;
  logic               level_q, press_q, release_q;
  logic [COUNT_W-1:0] count_q;
  logic               long_q;

  // Sync flops reset to the released (high) pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.btn_n_raw;
      sync2 <= sync1;
    end
  end

  assign btn_s = ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RELEASED;
      prev_state <= RELEASED;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      prev_state <= state;
      cnt        <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  // Strobes key off the state we just entered and where we came from, so only accepted edges fire.
  always_comb begin
    level_d   = (state == PRESSED) || (state == RELEASE_WAIT);
    press_d   = (state == PRESSED) && (prev_state == PRESS_WAIT);
    release_d = (state == RELEASED) && (prev_state == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      if (press_d && (count_q != {COUNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              armed;

  // Hold count survives a bounce into RELEASE_WAIT; it saturates so the strobe cannot repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      armed    <= 1'b1;
      long_q   <= 1'b0;
    end else begin
      long_q <= armed && (hold_cnt == HOLD_LIMIT);
      if (armed && (hold_cnt == HOLD_LIMIT)) begin
        armed <= 1'b0;
      end else if (release_d) begin
        armed <= 1'b1;
      end
      if ((state == PRESSED) && (hold_cnt != HOLD_LIMIT)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else if ((state == RELEASED) || (state == PRESS_WAIT)) begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign long_q = 1'b0;
`endif

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.press_count   = count_q;
  assign bus.long_press    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: each driven press/release pushes its expected strobe,
// and a negedge monitor pops and compares every strobe the debouncer emits.
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int CW   = 2;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 3;

  localparam int KIND_PRESS   = 0;
  localparam int KIND_RELEASE = 1;
  localparam int KIND_LONG    = 2;

  typedef struct {
    int kind;
    int cycle;
    int count;
  } event_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  event_t exp_q[$];
  int     cyc       = 0;
  int     checks    = 0;
  int     errors    = 0;
  int     exp_count = 0;
  int     long_seen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  button_debouncer_if #(.COUNT_W(CW)) bus ();

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DEB),
    .COUNT_W          (CW),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic push_event(input int kind, input int cycle, input int count);
    event_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.count = count;
    exp_q.push_back(e);
  endtask

  task automatic next_press_count();
    if (exp_count < (1 << CW) - 1) exp_count++;
  endtask

  task automatic handle_pulse(input int kind);
    event_t e;
    if (exp_q.size() == 0) begin
      checkOutput("spurious_pulse_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("pulse_kind", kind, e.kind);
      checkOutput("pulse_cycle", cyc, e.cycle);
      if (kind == KIND_PRESS) begin
        checkOutput("press_count", int'(bus.press_count), e.count);
        checkOutput("level_on_press", int'(bus.btn_level), 1);
      end else if (kind == KIND_RELEASE) begin
        checkOutput("level_on_release", int'(bus.btn_level), 0);
      end
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.press_pulse && bus.release_pulse) begin
        checkOutput("pulse_overlap", int'(bus.release_pulse), 0);
      end
      if (bus.press_pulse)   handle_pulse(KIND_PRESS);
      if (bus.release_pulse) handle_pulse(KIND_RELEASE);
      if (bus.long_press) begin
        long_seen++;
        handle_pulse(KIND_LONG);
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.btn_n_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_level", int'(bus.btn_level), 0);
      checkOutput("rst_press", int'(bus.press_pulse), 0);
      checkOutput("rst_release", int'(bus.release_pulse), 0);
      checkOutput("rst_count", int'(bus.press_count), 0);
      checkOutput("rst_long", int'(bus.long_press), 0);
    end
    bus.btn_n_raw = 1'b1;
    rst           = 1'b0;
    exp_count     = 0;
  endtask

  // One clean press held for hold cycles, then a clean release with settle time.
  task automatic applyStimulus(input int hold, input bit expect_long);
    int start;
    @(negedge clk);
    bus.btn_n_raw = 1'b0;
    start = cyc;
    next_press_count();
    push_event(KIND_PRESS, start + LAT, exp_count);
`ifdef BTN_LONG_PRESS_EN
    if (expect_long) push_event(KIND_LONG, start + LAT + LONG, 0);
`else
    if (expect_long) $display("[TB] long press not built, no strobe expected");
`endif
    repeat (hold) @(negedge clk);
    bus.btn_n_raw = 1'b1;
    push_event(KIND_RELEASE, cyc + LAT, 0);
    repeat (12) @(negedge clk);
    wait_drain();
  endtask

  task automatic drive_for(input logic value, input int cycles);
    bus.btn_n_raw = value;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int start;
    bus.btn_n_raw = 1'b0;

    $display("[TB] reset with pin held low");
    do_reset();

    $display("[TB] single-cycle glitches");
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      drive_for(1'b0, 1);
      drive_for(1'b1, 10);
    end
    wait_drain();
    checkOutput("glitch_count", int'(bus.press_count), 0);
    checkOutput("glitch_level", int'(bus.btn_level), 0);

    $display("[TB] clean press");
    applyStimulus(10, 1'b0);
    checkOutput("clean_count", int'(bus.press_count), 1);
    checkOutput("clean_level_after", int'(bus.btn_level), 0);

    $display("[TB] bouncing press");
    @(negedge clk);
    drive_for(1'b0, 3);
    drive_for(1'b1, 1);
    drive_for(1'b0, 3);
    drive_for(1'b1, 1);
    bus.btn_n_raw = 1'b0;
    start = cyc;
    next_press_count();
    push_event(KIND_PRESS, start + LAT, exp_count);
    repeat (12) @(negedge clk);
    checkOutput("bounce_level", int'(bus.btn_level), 1);
    bus.btn_n_raw = 1'b1;
    push_event(KIND_RELEASE, cyc + LAT, 0);
    repeat (12) @(negedge clk);
    wait_drain();
    checkOutput("bounce_count", int'(bus.press_count), 2);

    $display("[TB] press counter saturation");
    do_reset();
    for (int p = 0; p < 5; p++) applyStimulus(8, 1'b0);
    checkOutput("sat_count", int'(bus.press_count), 3);

    $display("[TB] long press");
    do_reset();
    long_seen = 0;
    applyStimulus(30, 1'b1);
    applyStimulus(15, 1'b0);
`ifdef BTN_LONG_PRESS_EN
    checkOutput("long_strobes", long_seen, 1);
`else
    checkOutput("long_strobes", long_seen, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
